// File: rtl/sda_gmem_read_arbiter.sv
// Two-requester AXI read-path arbiter: round-robin AR grant tagged on ARID,
// RID-routed R channel, per-requester outstanding-burst throttling.
module sda_gmem_read_arbiter #(
    parameter int unsigned AR_INFO_WIDTH   = 94,
    parameter int unsigned R_INFO_WIDTH    = 67,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                       ap_clk,
    input  logic                       reset,
    input  logic [1:0]                 s_arvalid,
    input  logic [2*AR_INFO_WIDTH-1:0] s_ar_info,
    output logic [1:0]                 s_arready,
    output logic [1:0]                 s_rvalid,
    output logic [R_INFO_WIDTH-1:0]    s_r_info,
    output logic                       s_rlast,
    input  logic [1:0]                 s_rready,
    output logic                       m_arvalid,
    output logic [AR_INFO_WIDTH-1:0]   m_ar_info,
    output logic                       m_arid,
    input  logic                       m_arready,
    input  logic                       m_rvalid,
    input  logic [R_INFO_WIDTH-1:0]    m_r_info,
    input  logic                       m_rlast,
    input  logic                       m_rid,
    output logic                       m_rready,
    output logic                       protocol_err
);

    localparam int unsigned      CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q [2];
    logic [CNT_W-1:0]         count_d [2];
    logic                     last_q, last_d;
    logic                     err_q, err_d;
    logic                     arvalid_q, arvalid_d;
    logic                     arid_q, arid_d;
    logic [AR_INFO_WIDTH-1:0] ar_info_q, ar_info_d;

    logic [1:0] elig;
    logic       sel;
    logic       grant;
    logic       r_done;

    // Round-robin selection: the requester not granted last wins a tie.
    always_comb begin
        elig[0] = s_arvalid[0] && (count_q[0] < CNT_MAX);
        elig[1] = s_arvalid[1] && (count_q[1] < CNT_MAX);
        sel     = (elig == 2'b11) ? ~last_q : elig[1];
        grant   = (state_q == IDLE) && (elig != 2'b00);
    end

    assign s_arready = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // R channel is a pure RID-steered passthrough with no storage.
    assign s_rvalid = {m_rvalid & m_rid, m_rvalid & ~m_rid};
    assign s_r_info = m_r_info;
    assign s_rlast  = m_rlast;
    assign m_rready = s_rready[m_rid];
    assign r_done   = m_rvalid & m_rready & m_rlast;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        ar_info_d = ar_info_q;
        count_d   = count_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = ISSUE;
                    arvalid_d = 1'b1;
                    arid_d    = sel;
                    last_d    = sel;
                    ar_info_d = sel ? s_ar_info[2*AR_INFO_WIDTH-1:AR_INFO_WIDTH]
                                    : s_ar_info[AR_INFO_WIDTH-1:0];
                end
            end
            ISSUE: begin
                if (m_arready) begin
                    state_d   = IDLE;
                    arvalid_d = 1'b0;
                end
            end
        endcase

        // Grant and completion on the same counter cancel out; zero saturates.
        for (int i = 0; i < 2; i++) begin
            if ((grant && (sel == 1'(i))) &&
                !(r_done && (m_rid == 1'(i)) && (count_q[i] != '0))) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end else if (!(grant && (sel == 1'(i))) &&
                         (r_done && (m_rid == 1'(i)) && (count_q[i] != '0))) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end
        end

        if (r_done && (count_q[m_rid] == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q[0] <= '0;
            count_q[1] <= '0;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            arid_q     <= 1'b0;
            ar_info_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q[0] <= count_d[0];
            count_q[1] <= count_d[1];
            last_q     <= last_d;
            err_q      <= err_d;
            arvalid_q  <= arvalid_d;
            arid_q     <= arid_d;
            ar_info_q  <= ar_info_d;
        end
    end

    assign m_arvalid    = arvalid_q;
    assign m_arid       = arid_q;
    assign m_ar_info    = ar_info_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_sda_gmem_read_arbiter.sv
// Bench for sda_gmem_read_arbiter: directed literal checks followed by random
// traffic compared every cycle against a transaction-level model.
module tb_sda_gmem_read_arbiter;

    localparam int AW   = 94;
    localparam int RW   = 67;
    localparam int MAXO = 8;

    logic            ap_clk = 1'b0;
    logic            reset;
    logic [1:0]      s_arvalid;
    logic [2*AW-1:0] s_ar_info;
    logic [1:0]      s_arready;
    logic [1:0]      s_rvalid;
    logic [RW-1:0]   s_r_info;
    logic            s_rlast;
    logic [1:0]      s_rready;
    logic            m_arvalid;
    logic [AW-1:0]   m_ar_info;
    logic            m_arid;
    logic            m_arready;
    logic            m_rvalid;
    logic [RW-1:0]   m_r_info;
    logic            m_rlast;
    logic            m_rid;
    logic            m_rready;
    logic            protocol_err;

    sda_gmem_read_arbiter dut (
        .ap_clk       (ap_clk),
        .reset        (reset),
        .s_arvalid    (s_arvalid),
        .s_ar_info    (s_ar_info),
        .s_arready    (s_arready),
        .s_rvalid     (s_rvalid),
        .s_r_info     (s_r_info),
        .s_rlast      (s_rlast),
        .s_rready     (s_rready),
        .m_arvalid    (m_arvalid),
        .m_ar_info    (m_ar_info),
        .m_arid       (m_arid),
        .m_arready    (m_arready),
        .m_rvalid     (m_rvalid),
        .m_r_info     (m_r_info),
        .m_rlast      (m_rlast),
        .m_rid        (m_rid),
        .m_rready     (m_rready),
        .protocol_err (protocol_err)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: in-flight burst counts, a pending AR slot, last winner.
    int          cnt [2];
    bit          busy;
    bit          last;
    bit          err;
    logic [AW-1:0] minfo;
    bit          mid;

    function automatic logic [1:0] exp_arready();
        bit e0, e1;
        e0 = s_arvalid[0] && (cnt[0] < MAXO);
        e1 = s_arvalid[1] && (cnt[1] < MAXO);
        if (busy || !(e0 || e1)) return 2'b00;
        if (e0 && e1) return (last == 1'b0) ? 2'b10 : 2'b01;
        return e0 ? 2'b01 : 2'b10;
    endfunction

    function automatic bit rdone();
        return m_rvalid && s_rready[m_rid] && m_rlast;
    endfunction

    always @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            cnt[0] <= 0;
            cnt[1] <= 0;
            busy   <= 1'b0;
            last   <= 1'b1;
            err    <= 1'b0;
            minfo  <= '0;
            mid    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= cnt[i]
                        + ((exp_arready() == (2'b01 << i)) ? 1 : 0)
                        - ((rdone() && int'(m_rid) == i && cnt[i] > 0) ? 1 : 0);
            end
            if (rdone() && cnt[m_rid] == 0) err <= 1'b1;
            if (exp_arready() != 2'b00) begin
                busy  <= 1'b1;
                last  <= (exp_arready() == 2'b10);
                mid   <= (exp_arready() == 2'b10);
                minfo <= (exp_arready() == 2'b10) ? s_ar_info[2*AW-1:AW] : s_ar_info[AW-1:0];
            end else if (busy && m_arready) begin
                busy <= 1'b0;
            end
        end
    end

    always @(negedge ap_clk) begin
        chk("m_s_arready", 128'(s_arready), 128'(exp_arready()));
        chk("m_m_arvalid", 128'(m_arvalid), 128'(busy));
        chk("m_m_ar_info", 128'(m_ar_info), 128'(minfo));
        chk("m_m_arid", 128'(m_arid), 128'(mid));
        chk("m_s_rvalid", 128'(s_rvalid), 128'({m_rvalid && m_rid == 1'b1, m_rvalid && m_rid == 1'b0}));
        chk("m_m_rready", 128'(m_rready), 128'(s_rready[m_rid]));
        chk("m_s_r_info", 128'(s_r_info), 128'(m_r_info));
        chk("m_s_rlast", 128'(s_rlast), 128'(m_rlast));
        chk("m_protocol_err", 128'(protocol_err), 128'(err));
    end

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    logic [AW-1:0] pa, pb, pc;
    bit            rs [5];
    bit            exp_id;

    initial begin
        reset = 1'b1; s_arvalid = '0; s_ar_info = '0; s_rready = '0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_r_info = '0; m_rlast = 1'b0; m_rid = 1'b0;
        pa = 94'h2A5A_5A5A_1111_2222_3333_4444;
        pb = 94'h1F0F_0F0F_DEAD_BEEF_CAFE_0001;
        pc = 94'h0123_4567_89AB_CDEF_0F1E_2D3C;
        rs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        #12;
        chk("rst_arready", 128'(s_arready), 128'(0));
        chk("rst_arvalid", 128'(m_arvalid), 128'(0));
        chk("rst_ar_info", 128'(m_ar_info), 128'(0));
        chk("rst_arid", 128'(m_arid), 128'(0));
        chk("rst_err", 128'(protocol_err), 128'(0));
        reset = 1'b0;

        // Single request from requester 0
        tick(); s_arvalid = 2'b01; s_ar_info = {pb, pa}; m_arready = 1'b1;
        #1 chk("single_arready", 128'(s_arready), 128'(2'b01));
        tick(); s_arvalid = 2'b00;
        #1 chk("single_arvalid", 128'(m_arvalid), 128'(1));
        chk("single_info", 128'(m_ar_info), 128'(pa));
        chk("single_arid", 128'(m_arid), 128'(0));
        chk("single_issue_rdy", 128'(s_arready), 128'(0));
        tick();
        #1 chk("single_done", 128'(m_arvalid), 128'(0));

        // Contention: requester 0 went last, so requester 1 leads the alternation
        s_arvalid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_id = (k % 2 == 0);
            #1 chk("cont_arready", 128'(s_arready), 128'(exp_id ? 2'b10 : 2'b01));
            tick();
            #1 chk("cont_arid", 128'(m_arid), 128'(exp_id));
            chk("cont_info", 128'(m_ar_info), 128'(exp_id ? pb : pa));
            tick();
        end

        // Back-pressure: five stalled ISSUE cycles while the payload inputs change
        m_arready = 1'b0;
        #1 chk("bp_grant", 128'(s_arready), 128'(2'b10));
        tick(); s_ar_info = {pc, pc};
        for (int j = 0; j < 5; j++) begin
            #1 chk("bp_arvalid", 128'(m_arvalid), 128'(1));
            chk("bp_info", 128'(m_ar_info), 128'(pb));
            chk("bp_arid", 128'(m_arid), 128'(1));
            chk("bp_arready", 128'(s_arready), 128'(0));
            if (j == 4) m_arready = 1'b1;
            else tick();
        end
        tick(); s_arvalid = 2'b00;
        #1 chk("bp_release", 128'(m_arvalid), 128'(0));

        // Outstanding limit: requester 0 at 4, raise to 8
        s_arvalid = 2'b01; s_ar_info = {pb, pa};
        for (int j = 0; j < 4; j++) begin
            #1 chk("lim_grant", 128'(s_arready), 128'(2'b01));
            tick(); tick();
        end
        #1 chk("lim_block0", 128'(s_arready), 128'(0));
        s_arvalid = 2'b11;
        #1 chk("lim_req1", 128'(s_arready), 128'(2'b10));
        tick(); tick();
        s_arvalid = 2'b01;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 1'b0; s_rready = 2'b01; m_r_info = RW'(77);
        #1 chk("lim_still", 128'(s_arready), 128'(0));
        chk("lim_rvalid", 128'(s_rvalid), 128'(2'b01));
        chk("lim_rready", 128'(m_rready), 128'(1));
        tick(); m_rvalid = 1'b0; m_rlast = 1'b0;
        #1 chk("lim_reopen", 128'(s_arready), 128'(2'b01));
        tick(); tick(); s_arvalid = 2'b00;

        // R routing to requester 1 with a same-cycle grant at RLAST (count1 = 5)
        m_rid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            m_rvalid = 1'b1; m_r_info = RW'(c + 100); s_rready = {rs[c], 1'b0};
            m_rlast = (c == 4); s_arvalid = (c == 4) ? 2'b10 : 2'b00;
            #1 chk("r_svalid", 128'(s_rvalid), 128'(2'b10));
            chk("r_mready", 128'(m_rready), 128'(rs[c]));
            chk("r_info", 128'(s_r_info), 128'(c + 100));
            if (c == 4) chk("r_same_grant", 128'(s_arready), 128'(2'b10));
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; s_arvalid = 2'b00;
        tick();
        s_arvalid = 2'b10;
        for (int j = 0; j < 3; j++) begin
            #1 chk("r_fill1", 128'(s_arready), 128'(2'b10));
            tick(); tick();
        end
        #1 chk("r_limit1", 128'(s_arready), 128'(0));
        s_arvalid = 2'b00;

        // Unmatched RLAST sets the sticky error
        reset = 1'b1; #1 reset = 1'b0;
        s_rready = 2'b01; m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 1'b0;
        tick(); m_rvalid = 1'b0; m_rlast = 1'b0;
        #1 chk("err_set", 128'(protocol_err), 128'(1));
        tick(); tick();
        #1 chk("err_sticky", 128'(protocol_err), 128'(1));

        // Reset while ISSUE holds a third burst
        s_arvalid = 2'b01; m_arready = 1'b1;
        tick(); tick(); tick(); tick();
        m_arready = 1'b0;
        tick(); s_arvalid = 2'b00;
        #1 chk("pre_rst_arvalid", 128'(m_arvalid), 128'(1));
        reset = 1'b1;
        #1 chk("mid_rst_arvalid", 128'(m_arvalid), 128'(0));
        chk("mid_rst_err", 128'(protocol_err), 128'(0));
        chk("mid_rst_info", 128'(m_ar_info), 128'(0));
        tick(); reset = 1'b0; m_arready = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom % 400 == 0) reset = 1'b1;
            s_arvalid = 2'($urandom);
            s_ar_info = (2*AW)'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            m_arready = ($urandom % 3 != 0);
            s_rready  = 2'($urandom);
            m_rvalid  = ($urandom % 2 == 0);
            m_rid     = 1'($urandom);
            m_r_info  = RW'({$urandom(), $urandom(), $urandom()});
            m_rlast   = m_rvalid && (cnt[m_rid] > 0) && ($urandom % 3 == 0);
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
